// File: rtl/enable_mux_pkg.sv
// enable_mux_pkg: shared defaults for the enable-gated 2-to-1 mux.
package enable_mux_pkg;
   localparam int DEF_WIDTH = 1;
   localparam logic DIS_BIT = 1'b0;
endpackage

// File: rtl/enable_mux_2to1_pipe_reg.sv
// pipe_reg: W-bit register with synchronous active-high reset to RST_VAL.
module pipe_reg #(
   parameter int W = 2,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      q <= rst ? RST_VAL : d;
endmodule

// File: rtl/enable_mux_2to1.sv
// enable_mux_2to1: 2-to-1 mux forced to DIS_VAL when disabled, optionally registered.
module enable_mux_2to1
   import enable_mux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int PIPE = 1,
   parameter logic [WIDTH-1:0] DIS_VAL = {WIDTH{DIS_BIT}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             sel,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic             out_vld
);
   logic [WIDTH-1:0] nxt;
   always_comb
      nxt = en ? (sel ? in1 : in0) : DIS_VAL;
   generate
      if (PIPE != 0) begin : g_pipe
         logic [WIDTH:0] q;
         pipe_reg #(.W(WIDTH + 1), .RST_VAL({DIS_VAL, 1'b0})) u_reg (
            .clk(clk),
            .rst(rst),
            .d  ({nxt, en}),
            .q  (q)
         );
         assign {out, out_vld} = q;
      end else begin : g_comb
         // clk/rst are kept as ports for a uniform interface but unused here
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign out = nxt;
         assign out_vld = en;
      end
   endgenerate
endmodule

// File: tb/tb_enable_mux_2to1.sv
// tb_enable_mux_2to1: directed checks of combinational, registered and 8-bit mux variants.
module tb_enable_mux_2to1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in0 = 1'b0, in1 = 1'b0, sel = 1'b0, en = 1'b0;
   logic [7:0] a0 = 8'h00, a1 = 8'h00;
   logic sel8 = 1'b0, en8 = 1'b0;
   logic out_c, vld_c, out_p, vld_p, vld_8;
   logic [7:0] out_8;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   enable_mux_2to1 #(.WIDTH(1), .PIPE(0)) d_comb (
      .clk(clk), .rst(rst), .in0(in0), .in1(in1), .sel(sel), .en(en),
      .out(out_c), .out_vld(vld_c)
   );
   enable_mux_2to1 #(.WIDTH(1), .PIPE(1)) d_pipe (
      .clk(clk), .rst(rst), .in0(in0), .in1(in1), .sel(sel), .en(en),
      .out(out_p), .out_vld(vld_p)
   );
   enable_mux_2to1 #(.WIDTH(8), .PIPE(1), .DIS_VAL(8'hA5)) d_w8 (
      .clk(clk), .rst(rst), .in0(a0), .in1(a1), .sel(sel8), .en(en8),
      .out(out_8), .out_vld(vld_8)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // drive one vector: comb variant checked now, registered variant after the next edge
   task automatic apply(input string tag, input logic e, input logic s, input logic a,
                        input logic b, input logic x_out, input logic x_vld);
      en = e; sel = s; in0 = a; in1 = b;
      #1;
      chk({tag, "_comb_out"}, {7'd0, out_c}, {7'd0, x_out});
      chk({tag, "_comb_vld"}, {7'd0, vld_c}, {7'd0, x_vld});
      @(posedge clk); #1;
      chk({tag, "_pipe_out"}, {7'd0, out_p}, {7'd0, x_out});
      chk({tag, "_pipe_vld"}, {7'd0, vld_p}, {7'd0, x_vld});
   endtask

   initial begin
      en8 = 1'b1; sel8 = 1'b1; a0 = 8'h3C; a1 = 8'hC3;
      @(posedge clk); #1;
      chk("rst_pipe_out", {7'd0, out_p}, 8'h00);
      chk("rst_pipe_vld", {7'd0, vld_p}, 8'h00);
      chk("rst_w8_out", out_8, 8'hA5);
      chk("rst_w8_vld", {7'd0, vld_8}, 8'h00);
      rst = 1'b0;
      en8 = 1'b0;
      // disabled sweep
      apply("dis_00_s0", 0, 0, 0, 0, 0, 0);
      apply("dis_00_s1", 0, 1, 0, 0, 0, 0);
      apply("dis_11_s0", 0, 0, 1, 1, 0, 0);
      apply("dis_11_s1", 0, 1, 1, 1, 0, 0);
      // sel=0 follows in0
      apply("s0_00", 1, 0, 0, 0, 0, 1);
      apply("s0_01", 1, 0, 0, 1, 0, 1);
      apply("s0_10", 1, 0, 1, 0, 1, 1);
      apply("s0_11", 1, 0, 1, 1, 1, 1);
      // sel=1 follows in1
      apply("s1_00", 1, 1, 0, 0, 0, 1);
      apply("s1_01", 1, 1, 0, 1, 1, 1);
      apply("s1_10", 1, 1, 1, 0, 0, 1);
      apply("s1_11", 1, 1, 1, 1, 1, 1);
      // 8-bit variant with non-zero idle value
      chk("w8_dis_out", out_8, 8'hA5);
      en8 = 1'b1; sel8 = 1'b1;
      @(posedge clk); #1;
      chk("w8_s1_out", out_8, 8'hC3);
      chk("w8_s1_vld", {7'd0, vld_8}, 8'h01);
      sel8 = 1'b0;
      @(posedge clk); #1;
      chk("w8_s0_out", out_8, 8'h3C);
      en8 = 1'b0;
      @(posedge clk); #1;
      chk("w8_off_out", out_8, 8'hA5);
      chk("w8_off_vld", {7'd0, vld_8}, 8'h00);
      // mid-stream reset
      en = 1'b1; sel = 1'b0; in0 = 1'b1; in1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_out", {7'd0, out_p}, 8'h01);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_out", {7'd0, out_p}, 8'h00);
      chk("mid_rst_vld", {7'd0, vld_p}, 8'h00);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_out", {7'd0, out_p}, 8'h01);
      chk("post_rst_vld", {7'd0, vld_p}, 8'h01);
      // back-to-back sel toggling
      in0 = 1'b0; in1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         sel = i[0];
         @(posedge clk); #1;
         chk($sformatf("b2b_%0d", i), {7'd0, out_p}, {7'd0, i[0]});
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
